// File: rtl/alu_control_pipe.sv
// alu_control_pipe
// Registered ALU control decoder with MULT/DIV sequencing.
//
// Decodes {ALUOp, ALUFunction} into an ALU operation code. The result
// appears one cycle after the op is accepted and is qualified by valid_out.
// MULT/DIV are handed to an iterative unit:
//   - md_start pulses once.
//   - md_busy/stall_out are held for MD_CYCLES cycles.
//   - A single done cycle then presents the MULT/DIV code with valid_out.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   valid_in      ALUOp/ALUFunction valid this cycle
//   ALUOp         class code from main control (low 3 bits decoded)
//   ALUFunction   funct field (low 6 bits decoded)
//   ALUOperation  registered operation code, zero-extended
//   valid_out     ALUOperation valid this cycle
//   stall_out     block busy, upstream must hold its inputs
//   md_start      one-cycle start pulse to the MULT/DIV unit
//   md_busy       MULT/DIV in progress
//   illegal_op    illegal decode flag, aligned with valid_out
//
// Build option
//   ALU_CTRL_ILLEGAL_TRAP_EN
//     Defined: illegal_op flags illegal decodes.
//     Undefined: illegal_op is tied low.
//
// Parameter minimums
//   OP_W >= 3, FUNCT_W >= 6, ALUOP_OUT_W >= 4, MD_CYCLES >= 2.
module alu_control_pipe #(
  parameter int OP_W        = 3,
  parameter int FUNCT_W     = 6,
  parameter int ALUOP_OUT_W = 4,
  parameter int MD_CYCLES   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic [OP_W-1:0]        ALUOp,
  input  logic [FUNCT_W-1:0]     ALUFunction,
  output logic [ALUOP_OUT_W-1:0] ALUOperation,
  output logic                   valid_out,
  output logic                   stall_out,
  output logic                   md_start,
  output logic                   md_busy,
  output logic                   illegal_op
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MD_RUN  = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  localparam int CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

  localparam logic [3:0] CODE_ILLEGAL = 4'b1001;

  logic [1:0]             state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [ALUOP_OUT_W-1:0] alu_op_reg;
  logic [ALUOP_OUT_W-1:0] md_code_reg;
  logic                   valid_reg;
  logic                   md_start_reg;

  logic                   op_hi_zero;
  logic                   fn_hi_zero;
  logic [3:0]             dec_code;
  logic                   dec_md;
  logic                   accept;

  // Any set bit above the decoded field makes the op illegal.
  if (OP_W > 3) begin : g_op_hi
    assign op_hi_zero = ~|ALUOp[OP_W-1:3];
  end else begin : g_op_nohi
    assign op_hi_zero = 1'b1;
  end

  if (FUNCT_W > 6) begin : g_fn_hi
    assign fn_hi_zero = ~|ALUFunction[FUNCT_W-1:6];
  end else begin : g_fn_nohi
    assign fn_hi_zero = 1'b1;
  end

  always_comb begin
    dec_code = CODE_ILLEGAL;
    dec_md   = 1'b0;
    if (op_hi_zero) begin
      case (ALUOp[2:0])
        3'b111: begin
          // R-type: the funct field only matters here.
          if (fn_hi_zero) begin
            case (ALUFunction[5:0])
              6'b100100: dec_code = 4'b0000;  // AND
              6'b100101: dec_code = 4'b0001;  // OR
              6'b100111: dec_code = 4'b0010;  // NOR
              6'b100000: dec_code = 4'b0011;  // ADD
              6'b100010: dec_code = 4'b0100;  // SUB
              6'b000000: dec_code = 4'b0101;  // SLL
              6'b000010: dec_code = 4'b0110;  // SRL
              6'b011000: begin                // MULT
                dec_code = 4'b1010;
                dec_md   = 1'b1;
              end
              6'b011010: begin                // DIV
                dec_code = 4'b1011;
                dec_md   = 1'b1;
              end
              default: dec_code = CODE_ILLEGAL;
            endcase
          end
        end
        3'b000:  dec_code = 4'b0111;          // LUI
        3'b001:  dec_code = 4'b0100;          // BEQ
        3'b010:  dec_code = 4'b0011;          // LW/SW
        3'b100:  dec_code = 4'b0011;          // ADDI
        3'b101:  dec_code = 4'b0001;          // ORI
        3'b110:  dec_code = 4'b0000;          // ANDI
        default: dec_code = CODE_ILLEGAL;
      endcase
    end
  end

  assign md_busy   = (state_reg == MD_RUN);
  assign stall_out = md_busy;
  assign accept    = valid_in && !stall_out;

  // IDLE and MD_DONE accept new work identically.
  // MD_DONE differs only in the registered outputs it presents.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      alu_op_reg   <= '0;
      md_code_reg  <= '0;
      valid_reg    <= 1'b0;
      md_start_reg <= 1'b0;
    end else begin
      valid_reg    <= 1'b0;
      md_start_reg <= 1'b0;
      case (state_reg)
        MD_RUN: begin
          if (cnt_reg == '0) begin
            state_reg  <= MD_DONE;
            valid_reg  <= 1'b1;
            alu_op_reg <= md_code_reg;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          if (accept) begin
            if (dec_md) begin
              // ALUOperation keeps its old value until the done cycle.
              state_reg    <= MD_RUN;
              cnt_reg      <= CNT_LOAD;
              md_start_reg <= 1'b1;
              md_code_reg  <= ALUOP_OUT_W'(dec_code);
            end else begin
              valid_reg  <= 1'b1;
              alu_op_reg <= ALUOP_OUT_W'(dec_code);
            end
          end
        end
      endcase
    end
  end

  assign ALUOperation = alu_op_reg;
  assign valid_out    = valid_reg;
  assign md_start     = md_start_reg;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  // An illegal code can never be a MULT/DIV.
  // An illegal op therefore always completes in one cycle, never via MD_RUN.
  logic dec_illegal;
  logic illegal_reg;

  assign dec_illegal = (dec_code == CODE_ILLEGAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= accept && dec_illegal;
    end
  end

  assign illegal_op = illegal_reg;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_pipe.sv
// Testbench for alu_control_pipe, built with MD_CYCLES = 4.
//
// Scoreboard
//   - An {illegal, code} pair is pushed when an input is accepted.
//   - The pair is popped and compared when valid_out rises.
//
// Directed checks cover:
//   - reset state
//   - stall length and the md_start pulse
//   - same-cycle accept on the done cycle
//   - abort by reset
module tb_alu_control_pipe;

  localparam int OP_W        = 3;
  localparam int FUNCT_W     = 6;
  localparam int ALUOP_OUT_W = 4;
  localparam int MD_CYCLES   = 4;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   valid_in = 1'b0;
  logic [OP_W-1:0]        alu_op = '0;
  logic [FUNCT_W-1:0]     alu_function = '0;
  logic [ALUOP_OUT_W-1:0] alu_operation;
  logic                   valid_out;
  logic                   stall_out;
  logic                   md_start;
  logic                   md_busy;
  logic                   illegal_op;

  // Expected result for whatever is currently driven on the inputs.
  logic [3:0] exp_code_in = '0;
  logic       exp_ill_in  = 1'b0;

  logic [4:0] sb_q[$];
  int checks = 0;
  int passed = 0;

  alu_control_pipe #(
    .OP_W        (OP_W),
    .FUNCT_W     (FUNCT_W),
    .ALUOP_OUT_W (ALUOP_OUT_W),
    .MD_CYCLES   (MD_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .ALUOp        (alu_op),
    .ALUFunction  (alu_function),
    .ALUOperation (alu_operation),
    .valid_out    (valid_out),
    .stall_out    (stall_out),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .illegal_op   (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  // Pop first: valid_out reflects an earlier accept.
  // Then push whatever the coming rising edge will accept.
  always @(negedge clk) begin
    logic [4:0] e;
    if (reset) begin
      sb_q.delete();
    end else begin
      if (valid_out) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 32'(valid_out), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("code", 32'(alu_operation), 32'(e[3:0]));
          check("illegal_op", 32'(illegal_op), 32'(e[4]));
        end
      end
      if (valid_in && !stall_out) sb_q.push_back({exp_ill_in, exp_code_in});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] op, input logic [5:0] fn,
                        input logic [3:0] code, input logic ill);
    valid_in     = 1'b1;
    alu_op       = op;
    alu_function = fn;
    exp_code_in  = code;
    exp_ill_in   = ill & TRAP;
  endtask

  // Present one op and hold it until it is accepted (bounded wait).
  task automatic drive(input logic [2:0] op, input logic [5:0] fn,
                       input logic [3:0] code, input logic ill);
    int n;
    set_in(op, fn, code, ill);
    n = 0;
    while (stall_out && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("drive_timeout", 32'(stall_out), 32'd0);
    tick();
    valid_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(valid_out), 32'd0);
    check({tag, "_aluop"}, 32'(alu_operation), 32'd0);
    check({tag, "_stall"}, 32'(stall_out), 32'd0);
    check({tag, "_start"}, 32'(md_start), 32'd0);
    check({tag, "_busy"}, 32'(md_busy), 32'd0);
    check({tag, "_illegal"}, 32'(illegal_op), 32'd0);
  endtask

  initial begin
    int n;
    int stall_cnt;
    int start_cnt;
    int valid_cnt;
    logic [2:0] b2b_op[3];
    logic [3:0] b2b_code[3];

    b2b_op   = '{3'b100, 3'b101, 3'b000};
    b2b_code = '{4'b0011, 4'b0001, 4'b0111};

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    check_all_zero("reset");

    // SUB: latency 1, no stall
    drive(3'b111, 6'b100010, 4'b0100, 1'b0);
    check("sub_valid", 32'(valid_out), 32'd1);
    check("sub_stall", 32'(stall_out), 32'd0);
    tick();
    check("idle_valid", 32'(valid_out), 32'd0);
    check("hold_aluop", 32'(alu_operation), 32'h4);

    // Back-to-back ADDI, ORI, LUI: valid_out on three consecutive cycles
    for (int i = 0; i < 3; i++) begin
      set_in(b2b_op[i], 6'b011000, b2b_code[i], 1'b0);
      tick();
      check("b2b_valid", 32'(valid_out), 32'd1);
    end
    valid_in = 1'b0;
    tick();

    // MULT: one md_start, MD_CYCLES of stall, then a single done cycle.
    // A SUB offered during the stall must be ignored.
    set_in(3'b111, 6'b011000, 4'b1010, 1'b0);
    tick();
    valid_in = 1'b0;
    check("mult_start", 32'(md_start), 32'd1);
    check("mult_busy", 32'(md_busy), 32'd1);
    check("mult_no_valid", 32'(valid_out), 32'd0);
    stall_cnt = 0;
    start_cnt = 0;
    n = 0;
    while (stall_out && n < 20) begin
      stall_cnt++;
      start_cnt += int'(md_start);
      if (n < 2) set_in(3'b111, 6'b100010, 4'b0100, 1'b0);
      else valid_in = 1'b0;
      tick();
      n++;
    end
    check("mult_stall_cycles", 32'(stall_cnt), 32'(MD_CYCLES));
    check("mult_start_pulses", 32'(start_cnt), 32'd1);
    check("mult_done_valid", 32'(valid_out), 32'd1);
    check("mult_done_busy", 32'(md_busy), 32'd0);
    tick();
    check("mult_once", 32'(valid_out), 32'd0);

    // DIV followed by a held AND, accepted on the done cycle
    set_in(3'b111, 6'b011010, 4'b1011, 1'b0);
    tick();
    set_in(3'b111, 6'b100100, 4'b0000, 1'b0);
    n = 0;
    while (stall_out && n < 20) begin
      tick();
      n++;
    end
    check("div_done_valid", 32'(valid_out), 32'd1);
    check("div_done_stall", 32'(stall_out), 32'd0);
    tick();
    valid_in = 1'b0;
    check("and_valid", 32'(valid_out), 32'd1);
    check("and_stall", 32'(stall_out), 32'd0);
    tick();
    check("and_once", 32'(valid_out), 32'd0);

    // DIV aborted by reset in the second MD_RUN cycle
    set_in(3'b111, 6'b011010, 4'b1011, 1'b0);
    tick();
    valid_in = 1'b0;
    tick();
    check("abort_busy_before", 32'(md_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("abort");
    valid_cnt = 0;
    for (int i = 0; i < MD_CYCLES + 4; i++) begin
      valid_cnt += int'(valid_out) + int'(stall_out);
      tick();
    end
    check("abort_no_completion", 32'(valid_cnt), 32'd0);
    drive(3'b001, 6'b000000, 4'b0100, 1'b0);
    check("after_abort_valid", 32'(valid_out), 32'd1);

    // Illegal decodes and boundaries
    drive(3'b111, 6'b111111, 4'b1001, 1'b1);
    check("illegal_code", 32'(alu_operation), 32'h9);
    check("illegal_flag", 32'(illegal_op), 32'(TRAP));
    drive(3'b011, 6'b100000, 4'b1001, 1'b1);
    drive(3'b111, 6'b011001, 4'b1001, 1'b1);
    drive(3'b100, 6'b011010, 4'b0011, 1'b0);
    check("addi_md_funct_no_stall", 32'(stall_out), 32'd0);
    drive(3'b010, 6'b111111, 4'b0011, 1'b0);
    drive(3'b110, 6'b000000, 4'b0000, 1'b0);
    drive(3'b111, 6'b100111, 4'b0010, 1'b0);
    drive(3'b111, 6'b000000, 4'b0101, 1'b0);
    drive(3'b111, 6'b000010, 4'b0110, 1'b0);
    drive(3'b111, 6'b100101, 4'b0001, 1'b0);
    drive(3'b111, 6'b100000, 4'b0011, 1'b0);
    check("legal_after_illegal_flag", 32'(illegal_op), 32'd0);
    repeat (3) tick();

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
